// File: rtl/ps2_kbd_tx.sv
// ============================================================================
// Module   : ps2_kbd_tx
// Purpose  : Device-side PS/2 keyboard transmitter. Buffers scancode bytes in
//            a FIFO and serialises each one as an 11-bit PS/2 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_kbd_tx #(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 16,
    parameter int DEPTH      = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     ps2_clk,
    output logic                     ps2_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_PW = $clog2(2 * CLK_DIV);
    localparam int c_GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_PW-1:0] c_PH_LAST  = c_PW'(2 * CLK_DIV - 1);
    localparam logic [c_PW-1:0] c_PH_HIGH  = c_PW'(CLK_DIV);
    localparam logic [3:0]      c_BIT_LAST = 4'd10;
    localparam logic [c_GW-1:0] c_GAP      = c_GW'(GAP_CYCLES);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // ------------------------------------------------------------------ FIFO
    logic [7:0]      mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q;
    logic [c_AW-1:0] rd_ptr_q;
    logic [c_CW-1:0] count_q;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_head;

    assign in_ready = (count_q != c_FULL);
    assign w_push   = in_valid && in_ready;
    assign w_head   = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CW'(1);
                2'b01:   count_q <= count_q - c_CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // --------------------------------------------------------------- framer
    logic [0:0]      state_q, state_d;
    logic [c_PW-1:0] phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [9:0]      frame_q, frame_d;
    logic [c_GW-1:0] gap_q, gap_d;
    logic            ps2_clk_q, ps2_clk_d;
    logic            ps2_data_q, ps2_data_d;
    logic            w_phase_end;
    logic            w_frame_end;
    logic [c_PW-1:0] w_phase_inc;

    assign w_pop       = (state_q == c_ST_IDLE) && (gap_q == '0) && (count_q != '0);
    assign w_phase_end = (phase_q == c_PH_LAST);
    assign w_frame_end = w_phase_end && (bit_q == c_BIT_LAST);
    assign w_phase_inc = phase_q + c_PW'(1);

    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign busy     = (state_q == c_ST_SEND) || (count_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= c_ST_IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            frame_q    <= '1;
            gap_q      <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            gap_q      <= gap_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_pop)       state_d = c_ST_SEND;
            c_ST_SEND: if (w_frame_end) state_d = c_ST_IDLE;
            default:                    state_d = c_ST_IDLE;
        endcase
    end

    // frame_q holds the bits still to send after the start bit, LSB next;
    // the outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        phase_d    = phase_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        gap_d      = gap_q;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        case (state_q)
            c_ST_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - c_GW'(1);
                end
                if (w_pop) begin
                    frame_d    = {1'b1, ~^w_head, w_head};
                    phase_d    = '0;
                    bit_d      = '0;
                    ps2_data_d = 1'b0;
                end
            end
            c_ST_SEND: begin
                if (w_frame_end) begin
                    gap_d = c_GAP;
                end else if (w_phase_end) begin
                    phase_d    = '0;
                    bit_d      = bit_q + 4'd1;
                    frame_d    = {1'b1, frame_q[9:1]};
                    ps2_data_d = frame_q[0];
                end else begin
                    phase_d    = w_phase_inc;
                    ps2_clk_d  = (w_phase_inc < c_PH_HIGH);
                    ps2_data_d = ps2_data_q;
                end
            end
            default: begin
                gap_d = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_tx.sv
// ============================================================================
// Module   : tb_ps2_kbd_tx
// Purpose  : Self-checking bench for ps2_kbd_tx: cycle model, line decoder,
//            directed frame/gap/full/reset cases and a random byte stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_kbd_tx;

    localparam int CLK_DIV    = 8;
    localparam int GAP_CYCLES = 16;
    localparam int DEPTH      = 8;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int FRAME      = 22 * CLK_DIV;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          ps2_clk;
    logic          ps2_data;
    logic          busy;
    logic [CW-1:0] count;

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .DEPTH      (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .count    (count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return b[i-1];
        else if (i == 9) return ~^b;
        else             return 1'b1;
    endfunction

    // ---------------------------------------------------------------- model
    logic [7:0] q[$];
    logic [7:0] exp_rx[$];
    bit         m_init = 0;
    bit         m_send = 0;
    int         m_k = 0;
    int         m_gap = 0;
    logic [7:0] m_cur = 8'h00;
    int         rst_seen = 0;

    always @(posedge clock) begin
        bit pushed;
        bit popped;
        if (reset) begin
            if (m_send && m_k < 21 * CLK_DIV && exp_rx.size() > 0) void'(exp_rx.pop_back());
            q.delete();
            m_send = 0;
            m_gap  = 0;
            m_k    = 0;
            m_init = 1;
            rst_seen++;
        end else if (m_init) begin
            pushed = in_valid && (q.size() != DEPTH);
            popped = !m_send && (m_gap == 0) && (q.size() != 0);
            if (m_send) begin
                m_k++;
                if (m_k == FRAME) begin
                    m_send = 0;
                    m_gap  = GAP_CYCLES;
                end
            end else if (popped) begin
                m_cur = q.pop_front();
                exp_rx.push_back(m_cur);
                m_send = 1;
                m_k    = 0;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (pushed) q.push_back(in_data);
        end
    end

    // ------------------------------------------- per-cycle compare + decoder
    int          nb = 0;
    int          seen_rst = 0;
    int          n_dec = 0;
    logic [10:0] rb = '1;
    logic        prev_clk = 1'b1;

    always @(negedge clock) begin
        logic          ec, ed, er, eb;
        logic [CW-1:0] ecnt;
        if (seen_rst != rst_seen) begin
            seen_rst = rst_seen;
            nb = 0;
        end
        if (m_init) begin
            ec = 1'b1;
            ed = 1'b1;
            if (m_send) begin
                ec = ((m_k % (2 * CLK_DIV)) < CLK_DIV);
                ed = fbit(m_cur, m_k / (2 * CLK_DIV));
            end
            er   = (q.size() != DEPTH);
            eb   = m_send || (q.size() != 0);
            ecnt = CW'(q.size());
            chk("cycle{clk,data,ready,busy,count}", {ps2_clk, ps2_data, in_ready, busy, count},
                {ec, ed, er, eb, ecnt});
        end
        if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            rb[nb] = ps2_data;
            nb++;
            if (nb == 11) begin
                nb = 0;
                n_dec++;
                chk("rx_start_bit", rb[0], 0);
                chk("rx_stop_bit", rb[10], 1);
                chk("rx_parity_odd", ^rb[9:1], 1);
                if (exp_rx.size() == 0) chk("rx_unexpected_frame", rb[8:1], 32'hFFFF_FFFF);
                else chk("rx_byte", rb[8:1], exp_rx.pop_front());
            end
        end
        prev_clk = ps2_clk;
    end

    // ------------------------------------------------------------ stimulus
    task automatic offer(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic observe_frame(output logic [10:0] bits, output int nfall,
                                 output int len, output int waited);
        logic pc;
        int   n;
        bits = '1; nfall = 0; len = 0; waited = 0;
        while (ps2_data !== 1'b0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (ps2_data !== 1'b0) begin
            chk("frame_start_timeout", ps2_data, 0);
            return;
        end
        pc = ps2_clk;
        n  = 0;
        while (n < 4 * FRAME) begin
            @(negedge clock);
            n++;
            if (pc && !ps2_clk && nfall < 11) begin
                bits[nfall] = ps2_data;
                nfall++;
            end
            pc = ps2_clk;
            if (nfall == 11 && ps2_clk) break;
        end
        len = n;
    endtask

    task automatic drain();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_busy_low", busy, 0);
        repeat (GAP_CYCLES + 4) @(negedge clock);
    endtask

    initial begin
        logic [10:0] bits;
        int          nf, len, w, n, acc, dec0, guard;
        logic        hi, pc, last_rdy;
        logic [CW-1:0] last_cnt;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_ps2_clk", ps2_clk, 1);
        chk("reset_ps2_data", ps2_data, 1);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);

        // single 0x1C frame
        offer(8'h1C);
        chk("t1_idle_at_t+1", ps2_data, 1);
        @(negedge clock);
        chk("t1_start_at_t+2", ps2_data, 0);
        observe_frame(bits, nf, len, w);
        chk("t1_bits", bits, 11'h438);
        chk("t1_falling_edges", nf, 11);
        chk("t1_frame_cycles", len, 176);
        drain();

        // parity of 0x00 and 0xFF
        offer(8'h00);
        offer(8'hFF);
        observe_frame(bits, nf, len, w);
        chk("t2_00_data", bits[8:1], 8'h00);
        chk("t2_00_parity", bits[9], 1);
        chk("t2_00_stop", bits[10], 1);
        observe_frame(bits, nf, len, w);
        chk("t2_FF_data", bits[8:1], 8'hFF);
        chk("t2_FF_parity", bits[9], 1);
        chk("t2_FF_stop", bits[10], 1);
        drain();

        // inter-frame gap
        offer(8'hF0);
        offer(8'h1C);
        observe_frame(bits, nf, len, w);
        chk("t3_first_byte", bits[8:1], 8'hF0);
        n  = 0;
        hi = 1'b1;
        while (ps2_data !== 1'b0 && n < 200) begin
            if (ps2_clk !== 1'b1) hi = 1'b0;
            @(negedge clock);
            n++;
        end
        chk("t3_gap_cycles", n, GAP_CYCLES + 1);
        chk("t3_clk_high_in_gap", hi, 1);
        observe_frame(bits, nf, len, w);
        chk("t3_second_wait", w, 0);
        chk("t3_second_byte", bits[8:1], 8'h1C);
        drain();

        // overfill
        acc  = 0;
        dec0 = n_dec;
        last_rdy = 1'b1;
        last_cnt = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            last_rdy = in_ready;
            last_cnt = count;
            if (in_ready) acc++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("t4_accepted", acc, DEPTH + 1);
        chk("t4_last_offer_ready", last_rdy, 0);
        chk("t4_last_offer_count", last_cnt, DEPTH);
        drain();
        chk("t4_frames_out", n_dec - dec0, DEPTH + 1);

        // reset during data bit 4 of 0xA5
        offer(8'hA5);
        nf = 0; n = 0; pc = ps2_clk;
        while (nf < 5 && n < 1000) begin
            @(negedge clock);
            n++;
            if (pc && !ps2_clk) nf++;
            pc = ps2_clk;
        end
        n = 0;
        while (ps2_clk !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk("t5_bit4_on_line", {ps2_clk, ps2_data}, 2'b10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_after_rst_clk", ps2_clk, 1);
        chk("t5_after_rst_data", ps2_data, 1);
        chk("t5_after_rst_count", count, 0);
        chk("t5_after_rst_busy", busy, 0);
        hi = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b0 + 1'b1) hi = 1'b0;
        end
        chk("t5_lines_quiet", hi, 1);

        // random stream
        acc   = 0;
        guard = 0;
        dec0  = n_dec;
        while (acc < 200 && guard < 60000) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            if (in_valid && in_ready) acc++;
            @(negedge clock);
            guard++;
        end
        in_valid = 1'b0;
        chk("rand_accepted", acc, 200);
        drain();
        chk("rand_frames_out", n_dec - dec0, 200);
        chk("rand_scoreboard_empty", exp_rx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
- Device-side PS/2 keyboard transmitter for simulation and FPGA test harnesses.
- Accepts scancode bytes over a valid/ready interface and buffers them in an internal FIFO.
- Serialises each byte as a standard 11-bit PS/2 frame, driving both ps2_clk and ps2_data.
- Its outputs connect directly to the ps2_clk/ps2_data inputs of the SoC's PS/2 keyboard receiver.
- Transmit-only: no host-to-device commands, no inhibit detection.

Parameters:
- CLK_DIV, 8: system-clock cycles per ps2_clk half-period; must be >= 2.
- GAP_CYCLES, 16: minimum idle cycles between the end of one frame and the start of the next.
- DEPTH, 8: FIFO depth in bytes; must be a power of 2 and >= 2.

Ports:
- clock, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous reset, active-high.
- in_valid, input, 1: a byte is offered on in_data.
- in_ready, output, 1: FIFO can accept a byte this cycle.
- in_data, input, 8: scancode byte.
- ps2_clk, output, 1: PS/2 clock line, idle high.
- ps2_data, output, 1: PS/2 data line, idle high.
- busy, output, 1: FIFO non-empty or a frame is in progress.
- count, output, $clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
Reset:
- Synchronous, active-high, highest priority.
- Next cycle: ps2_clk=1, ps2_data=1, in_ready=1, busy=0, count=0.
- FIFO pointers cleared, FSM in IDLE, gap counter cleared to 0.
- Reset asserted mid-frame aborts the frame immediately; lines return to idle on the next edge and the partial frame is not resent.

FIFO:
- Push when in_valid && in_ready.
- in_ready = (count != DEPTH), computed from the registered count only. A pop in the same cycle does not free a slot for a push while full.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop when not full: count unchanged, and both operations take effect.
- in_data is ignored when the push does not occur.

FSM states:
- IDLE:
  - ps2_clk=1, ps2_data=1.
  - Gap counter decrements to 0 and saturates there.
  - When gap==0 and FIFO non-empty: pop the head byte into the shift register, compute parity = ~^byte (odd parity), set bit index to 0, phase counter to 0, and go to SEND.
- SEND:
  - 11 bits in order: start (0), data[0]..data[7] (LSB first), parity, stop (1).
  - Each bit lasts 2*CLK_DIV cycles.
  - First CLK_DIV cycles: ps2_clk=1, ps2_data=bit value. ps2_data changes only on the first cycle of a high phase.
  - Next CLK_DIV cycles: ps2_clk=0, ps2_data held.
  - The receiver samples ps2_data on the ps2_clk falling edge.
  - After the low phase of the stop bit: go to IDLE, load gap counter with GAP_CYCLES, ps2_clk=1, ps2_data=1.
- Both ps2 outputs are registered; no glitches.

Timing:
- Frame length: exactly 22*CLK_DIV cycles.
- Byte pushed in cycle t into an empty FIFO with FSM in IDLE and gap==0:
  - popped at the edge ending t+1;
  - ps2_data=0 (start bit) is visible from cycle t+2.
- Next frame start: its start bit appears GAP_CYCLES+1 cycles after the previous frame ends (gap drain plus pop), and no earlier.

busy:
- busy = (state==SEND) || (count != 0).
- After the last frame, busy stays 0 during the gap.

Test Plan:
- Single byte 0x1C, CLK_DIV=8:
  - bits sampled at ps2_clk falling edges are 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity=0, stop);
  - 11 falling edges; frame lasts 176 cycles;
  - start bit appears 2 cycles after the push.
- Byte 0x00, then byte 0xFF:
  - parity bits are 1 and 1 respectively (odd parity over 9 bits);
  - stop bit is 1 in both frames.
- Back-to-back 0xF0, 0x1C:
  - idle-high interval between the stop-bit low phase ending and the next start bit is exactly GAP_CYCLES+1 cycles;
  - ps2_clk stays high throughout the interval.
- Push DEPTH+2 bytes on consecutive cycles from idle:
  - exactly DEPTH+1 accepted (the first is popped at t+1);
  - in_ready=0 on the last offer; count=DEPTH;
  - all accepted bytes emerge in order; busy falls after the final frame.
- Assert reset for 1 cycle during data bit 4 of 0xA5:
  - next cycle ps2_clk=1, ps2_data=1, count=0, busy=0;
  - no further ps2_clk edges until a new push.
- Loopback with the SoC PS/2 receiver, random 200 bytes, random in_valid gaps:
  - receiver returns an identical byte sequence;
  - no parity errors.
